// File: rtl/eth_pkg.sv
`default_nettype none
// eth_pkg: EtherType constants, header-length adjustments and frame FSM states. Rev 1.0
package eth_pkg;

  localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ETYPE_IPV6   = 16'h86DD;
  localparam int unsigned IPV4_HDR_ADJ = 14;
  localparam int unsigned IPV6_HDR_ADJ = 54;
  localparam int unsigned BEAT_BYTES   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  // Beats needed to carry len bytes, saturated to the 8-bit beat counter range.
  function automatic logic [7:0] beats_for_len(input logic [16:0] len);
    logic [16:0] b;
    b = (len + 17'(BEAT_BYTES - 1)) / 17'(BEAT_BYTES);
    return (b > 17'd255) ? 8'hFF : b[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_reg_slice.sv
`default_nettype none
// axis_reg_slice: one-deep full-throughput register stage for a valid/ready stream. Rev 1.0
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  assign s_ready_o = !valid_q || m_ready_i;
  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (s_ready_o) begin
      valid_q <= s_valid_i;
      if (s_valid_i) begin
        data_q <= s_data_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_ingress_checker.sv
`default_nettype none
// eth_ingress_checker: qualifies frames on EtherType/header length, forwards good
// frames through a register slice, drops bad ones whole and counts outcomes. Rev 1.0
module eth_ingress_checker
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int MIN_PKT_LEN = 64,
  parameter int MAX_PKT_LEN = 9018
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [31:0]           pkt_pass_cnt,
  output logic [31:0]           pkt_drop_cnt,
  output logic [31:0]           pkt_err_cnt
);

  state_e      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] pass_q, drop_q, err_q;

  logic [15:0] etype;
  logic [15:0] v4_len;
  logic [15:0] v6_len;
  logic [16:0] len_c;
  logic        is_v4, is_v6;
  logic        good_c;
  logic [7:0]  exp_c;

  logic        first_c;
  logic        drop_c;
  logic        accept_c;
  logic [7:0]  beat_cnt_c;
  logic [7:0]  exp_now_c;
  logic        user_c;
  logic        slice_ready;

  // Network byte order: byte n is tdata[8n+7:8n], so byte 12 is the high EtherType byte.
  assign etype  = {s_axis_tdata[103:96],  s_axis_tdata[111:104]};
  assign v4_len = {s_axis_tdata[135:128], s_axis_tdata[143:136]};
  assign v6_len = {s_axis_tdata[151:144], s_axis_tdata[159:152]};
  assign is_v4  = (etype == ETYPE_IPV4);
  assign is_v6  = (etype == ETYPE_IPV6);

  always_comb begin
    len_c = '0;
    if (is_v4) begin
      len_c = {1'b0, v4_len} + 17'(IPV4_HDR_ADJ);
    end else if (is_v6) begin
      len_c = {1'b0, v6_len} + 17'(IPV6_HDR_ADJ);
    end
  end

  assign good_c = (is_v4 || is_v6) &&
                  (len_c >= 17'(MIN_PKT_LEN)) && (len_c <= 17'(MAX_PKT_LEN));
  assign exp_c  = beats_for_len(len_c);

  assign first_c    = (state_q == IDLE);
  assign drop_c     = first_c ? !good_c : (state_q == DROP);
  // Dropped beats bypass the slice so a stalled downstream never blocks discarding.
  assign s_axis_tready = drop_c || slice_ready;
  assign accept_c   = s_axis_tvalid && s_axis_tready;
  assign beat_cnt_c = first_c ? 8'd1 : ((beat_q == 8'hFF) ? 8'hFF : beat_q + 8'd1);
  assign exp_now_c  = first_c ? exp_c : exp_q;
  assign user_c     = s_axis_tlast && (beat_cnt_c != exp_now_c);

  axis_reg_slice #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  ({s_axis_tlast, user_c, s_axis_tdata}),
    .s_valid_i (s_axis_tvalid && !drop_c),
    .s_ready_o (slice_ready),
    .m_data_o  ({m_axis_tlast, m_axis_tuser, m_axis_tdata}),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    exp_d   = exp_q;
    if (accept_c) begin
      beat_d = beat_cnt_c;
      if (first_c) begin
        exp_d = exp_c;
      end
      case (state_q)
        IDLE:    if (!s_axis_tlast) state_d = good_c ? PASS : DROP;
        PASS,
        DROP:    if (s_axis_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      exp_q   <= '0;
      pass_q  <= '0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      exp_q   <= exp_d;
      if (accept_c && s_axis_tlast) begin
        if (drop_c) begin
          drop_q <= drop_q + 32'd1;
        end else begin
          pass_q <= pass_q + 32'd1;
          if (user_c) begin
            err_q <= err_q + 32'd1;
          end
        end
      end
    end
  end

  assign pkt_pass_cnt = pass_q;
  assign pkt_drop_cnt = drop_q;
  assign pkt_err_cnt  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_ingress_checker.sv
`default_nettype none
// tb_eth_ingress_checker: scoreboard bench for the ingress checker. Rev 1.0
module tb_eth_ingress_checker;

  localparam int DW = 512;
  typedef logic [DW+1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [31:0]   pkt_pass_cnt;
  logic [31:0]   pkt_drop_cnt;
  logic [31:0]   pkt_err_cnt;

  eth_ingress_checker #(
    .DATA_WIDTH  (DW),
    .MIN_PKT_LEN (64),
    .MAX_PKT_LEN (9018)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .pkt_pass_cnt  (pkt_pass_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt),
    .pkt_err_cnt   (pkt_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW+1:0] got, input logic [DW+1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  beat_t exp_q[$];
  int    acc_q[$];
  bit    chk_lat = 1'b0;
  bit    tog = 1'b0;
  int    frames_out = 0;
  int    last_acc = 0;
  int    pass_e = 0;
  int    drop_e = 0;
  int    err_e = 0;
  beat_t mon_e;
  int    mon_a;

  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, '0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        chk("beat", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, mon_e);
        if (chk_lat) chk("latency", DW'(cyc - mon_a), 1);
        if (m_axis_tlast) frames_out++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tog) m_axis_tready = ~m_axis_tready;
  end

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Drives one frame; exp_good/exp_user are the hand-derived outcome for this header.
  task automatic send_frame(input logic [15:0] id, input logic [15:0] etype,
                            input logic [15:0] lenf, input int nbeats,
                            input bit exp_good, input bit exp_user,
                            input int abort_after = 0);
    logic [DW-1:0] d;
    int w;
    for (int b = 0; b < nbeats; b++) begin
      if (abort_after != 0 && b == abort_after) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      d = rnd512();
      d[15:0] = id;
      if (b == 0) begin
        d[8*12 +: 8] = etype[15:8];
        d[8*13 +: 8] = etype[7:0];
        if (etype == 16'h86DD) begin
          d[8*18 +: 8] = lenf[15:8];
          d[8*19 +: 8] = lenf[7:0];
        end else begin
          d[8*16 +: 8] = lenf[15:8];
          d[8*17 +: 8] = lenf[7:0];
        end
      end
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == nbeats - 1);
      w = 0;
      @(negedge clk);
      while (!s_axis_tready) begin
        w++;
        if (w > 200) begin
          chk("tready_timeout", 0, 1);
          s_axis_tvalid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      if (exp_good) begin
        exp_q.push_back({s_axis_tlast, s_axis_tlast & exp_user, d});
        acc_q.push_back(cyc);
      end
      last_acc = cyc;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (exp_good) begin
      pass_e++;
      if (exp_user) err_e++;
    end else begin
      drop_e++;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", DW'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pass"}, pkt_pass_cnt, pass_e);
    chk({tag, "_drop"}, pkt_drop_cnt, drop_e);
    chk({tag, "_err"},  pkt_err_cnt,  err_e);
  endtask

  initial begin
    int a1;
    int f0;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast",  m_axis_tlast, 0);
    chk("rst_tuser",  m_axis_tuser, 0);
    chk("rst_tdata",  m_axis_tdata, 0);
    chk_counters("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back minimum-length frames, IPv6 then IPv4.
    chk_lat = 1'b1;
    send_frame(16'd0, 16'h86DD, 16'd10, 1, 1'b1, 1'b0);
    a1 = last_acc;
    send_frame(16'd1, 16'h0800, 16'd50, 1, 1'b1, 1'b0);
    chk("back_to_back", DW'(last_acc - a1), 1);
    drain();
    chk_counters("t1");

    // Multi-beat frames with matching lengths: 400 B -> 7 beats, 800 B -> 13 beats.
    send_frame(16'd2, 16'h0800, 16'd386, 7, 1'b1, 1'b0);
    send_frame(16'd3, 16'h86DD, 16'd746, 13, 1'b1, 1'b0);
    drain();
    chk_counters("t2");

    // Bad EtherType and undersize frame dropped while downstream is stalled.
    chk_lat = 1'b0;
    m_axis_tready = 1'b0;
    send_frame(16'd4, 16'h0806, 16'd100, 3, 1'b0, 1'b0);
    chk("drop_no_valid", m_axis_tvalid, 0);
    send_frame(16'd5, 16'h0800, 16'd30, 1, 1'b0, 1'b0);
    chk("drop_no_valid2", m_axis_tvalid, 0);
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    chk_counters("t3");

    // Length boundaries: 63 dropped, 9019 dropped, 9018 passes (sent short -> tuser).
    send_frame(16'd6, 16'h0800, 16'd49,   1, 1'b0, 1'b0);
    send_frame(16'd7, 16'h0800, 16'd9005, 1, 1'b0, 1'b0);
    send_frame(16'd8, 16'h0800, 16'd9004, 2, 1'b1, 1'b1);
    drain();
    chk_counters("bounds");

    // 200 B header (4 beats) sent early and late.
    send_frame(16'd10, 16'h0800, 16'd186, 2, 1'b1, 1'b1);
    send_frame(16'd11, 16'h0800, 16'd186, 6, 1'b1, 1'b1);
    drain();
    chk_counters("t4");

    // 100 alternating single-beat frames with a toggling downstream ready.
    f0 = frames_out;
    tog = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) send_frame(16'(i), 16'h86DD, 16'd10, 1, 1'b1, 1'b0);
      else            send_frame(16'(i), 16'h0800, 16'd50, 1, 1'b1, 1'b0);
    end
    drain();
    tog = 1'b0;
    m_axis_tready = 1'b1;
    chk("t5_frames_out", DW'(frames_out - f0), 100);
    chk_counters("t5");

    // Reset in the middle of a 19-beat IPv6 frame.
    chk_lat = 1'b1;
    send_frame(16'd200, 16'h86DD, 16'd1162, 19, 1'b1, 1'b0, 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    pass_e = 0;
    drop_e = 0;
    err_e  = 0;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tdata",  m_axis_tdata, 0);
    chk_counters("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16'd201, 16'h0800, 16'd50, 1, 1'b1, 1'b0);
    drain();
    chk_counters("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
